// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared sizes and BHT counter encodings for the branch resolve slice
package pipe_pkg;

  localparam int BHT_DEPTH = 16;
  localparam int IDX_W     = 4;
  localparam int PC_W      = 8;
  localparam int CNT_W     = 16;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/sat_counter2.sv
// rtl/sat_counter2.sv - 2-bit saturating branch history counter step
module sat_counter2
  import pipe_pkg::*;
(
  input  bht_state_e state,
  input  logic       taken,
  output bht_state_e next_state
);

  always_comb begin
    next_state = state;
    if (taken) begin
      if (state != BHT_ST) next_state = bht_state_e'(state + 2'b01);
    end else begin
      if (state != BHT_SNT) next_state = bht_state_e'(state - 2'b01);
    end
  end

endmodule

// File: rtl/mem_branch_resolve.sv
// rtl/mem_branch_resolve.sv - MEM-stage branch resolution: BHT training, flush/redirect, stats
module mem_branch_resolve
  import pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_mem,
  input  logic             taken_mem,
  input  logic             prediction_mem,
  input  logic [PC_W-1:0]  pc_mem,
  input  logic [PC_W-1:0]  pc_plus_mem,
  input  logic [PC_W-1:0]  pc_branch_mem,
  input  logic             stall_mem,
  input  logic [PC_W-1:0]  fetch_pc,
  output logic             predict_taken,
  output logic             flush_out,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
  logic                      flush_q, flush_d;
  logic [PC_W-1:0]           redirect_q, redirect_d;
  logic [CNT_W-1:0]          branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]          mispredict_cnt_q, mispredict_cnt_d;

  logic             resolve;
  logic             mispredict;
  logic [IDX_W-1:0] upd_idx;
  bht_state_e       cur_state;
  bht_state_e       nxt_state;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{pc_mem[PC_W-1:IDX_W], fetch_pc[PC_W-1:IDX_W]};

  // The slot behind a pending flush is wrong-path, so it never resolves.
  assign resolve    = branch_mem & ~stall_mem & ~flush_q;
  assign mispredict = resolve & (taken_mem != prediction_mem);
  assign upd_idx    = pc_mem[IDX_W-1:0];
  assign cur_state  = bht_state_e'(bht_q[upd_idx]);

  sat_counter2 u_sat_counter2 (
    .state      (cur_state),
    .taken      (taken_mem),
    .next_state (nxt_state)
  );

  // Reads the registered table, so a same-cycle update is seen only next cycle.
  assign predict_taken = bht_q[fetch_pc[IDX_W-1:0]][1];

  always_comb begin
    bht_d            = bht_q;
    flush_d          = mispredict;
    redirect_d       = redirect_q;
    branch_cnt_d     = branch_cnt_q;
    mispredict_cnt_d = mispredict_cnt_q;
    if (resolve) begin
      bht_d[upd_idx] = nxt_state;
      if (branch_cnt_q != CNT_MAX) branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict) begin
      redirect_d = taken_mem ? pc_branch_mem : pc_plus_mem;
      if (mispredict_cnt_q != CNT_MAX) mispredict_cnt_d = mispredict_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= BHT_WNT;
      flush_q          <= 1'b0;
      redirect_q       <= '0;
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      bht_q            <= bht_d;
      flush_q          <= flush_d;
      redirect_q       <= redirect_d;
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign flush_out      = flush_q;
  assign redirect_pc    = redirect_q;
  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_mem_branch_resolve.sv
// tb/tb_mem_branch_resolve.sv - self-checking bench for mem_branch_resolve
module tb_mem_branch_resolve;

  logic        clk;
  logic        reset;
  logic        branch_mem;
  logic        taken_mem;
  logic        prediction_mem;
  logic [7:0]  pc_mem;
  logic [7:0]  pc_plus_mem;
  logic [7:0]  pc_branch_mem;
  logic        stall_mem;
  logic [7:0]  fetch_pc;
  logic        predict_taken;
  logic        flush_out;
  logic [7:0]  redirect_pc;
  logic [15:0] branch_cnt;
  logic [15:0] mispredict_cnt;

  int checks;
  int errors;

  int m_bht [16];
  int m_flush;
  int m_redir;
  int m_bcnt;
  int m_mcnt;

  mem_branch_resolve dut (
    .clk            (clk),
    .reset          (reset),
    .branch_mem     (branch_mem),
    .taken_mem      (taken_mem),
    .prediction_mem (prediction_mem),
    .pc_mem         (pc_mem),
    .pc_plus_mem    (pc_plus_mem),
    .pc_branch_mem  (pc_branch_mem),
    .stall_mem      (stall_mem),
    .fetch_pc       (fetch_pc),
    .predict_taken  (predict_taken),
    .flush_out      (flush_out),
    .redirect_pc    (redirect_pc),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of one clock edge, using the inputs held across it.
  function automatic void model_clock();
    int nf;
    int i;
    if (reset == 1'b0) begin
      for (int k = 0; k < 16; k++) m_bht[k] = 1;
      m_flush = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
      return;
    end
    nf = 0;
    if (branch_mem && !stall_mem && m_flush == 0) begin
      i = int'(pc_mem) % 16;
      m_bcnt = (m_bcnt + 1 > 65535) ? 65535 : m_bcnt + 1;
      if (taken_mem != prediction_mem) begin
        nf = 1;
        m_mcnt = (m_mcnt + 1 > 65535) ? 65535 : m_mcnt + 1;
        m_redir = taken_mem ? int'(pc_branch_mem) : int'(pc_plus_mem);
      end
      m_bht[i] = taken_mem ? ((m_bht[i] + 1 > 3) ? 3 : m_bht[i] + 1)
                           : ((m_bht[i] - 1 < 0) ? 0 : m_bht[i] - 1);
    end
    m_flush = nf;
  endfunction

  task automatic drive(input logic rs, input logic br, input logic tk, input logic pr,
                       input logic st, input logic [7:0] pc, input logic [7:0] pcp,
                       input logic [7:0] pcb, input logic [7:0] fpc);
    reset = rs; branch_mem = br; taken_mem = tk; prediction_mem = pr; stall_mem = st;
    pc_mem = pc; pc_plus_mem = pcp; pc_branch_mem = pcb; fetch_pc = fpc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic test_reset();
    do_reset();
    checks += 4;
    if (flush_out !== 1'b0) begin errors++; $display("FAIL reset_flush got %0b want 0", flush_out); end
    if (redirect_pc !== 8'h00) begin errors++; $display("FAIL reset_redirect got %h want 00", redirect_pc); end
    if (branch_cnt !== 16'h0) begin errors++; $display("FAIL reset_bcnt got %0d want 0", branch_cnt); end
    if (mispredict_cnt !== 16'h0) begin errors++; $display("FAIL reset_mcnt got %0d want 0", mispredict_cnt); end
    for (int i = 0; i < 16; i++) begin
      fetch_pc = 8'(i) | 8'h50;
      #1;
      checks++;
      if (predict_taken !== 1'b0) begin errors++; $display("FAIL reset_predict idx %0d got %0b want 0", i, predict_taken); end
      tick();
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 8'h40, 8'h05);
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin errors++; $display("FAIL mp_predict_pre got %0b want 0", predict_taken); end
    tick();
    checks += 4;
    if (flush_out !== 1'b1) begin errors++; $display("FAIL mp_flush got %0b want 1", flush_out); end
    if (redirect_pc !== 8'h40) begin errors++; $display("FAIL mp_redirect got %h want 40", redirect_pc); end
    if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL mp_mcnt got %0d want 1", mispredict_cnt); end
    if (branch_cnt !== 16'd1) begin errors++; $display("FAIL mp_bcnt got %0d want 1", branch_cnt); end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05);
    tick();
    checks += 3;
    if (flush_out !== 1'b0) begin errors++; $display("FAIL mp_flush_end got %0b want 0", flush_out); end
    if (redirect_pc !== 8'h40) begin errors++; $display("FAIL mp_redirect_hold got %h want 40", redirect_pc); end
    if (predict_taken !== 1'b1) begin errors++; $display("FAIL mp_bht5_weakT got %0b want 1", predict_taken); end
    // not-taken mispredict redirects to the fall-through PC
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h09, 8'h0A, 8'h77, 8'h00);
    tick();
    checks += 2;
    if (flush_out !== 1'b1) begin errors++; $display("FAIL mp_nt_flush got %0b want 1", flush_out); end
    if (redirect_pc !== 8'h0A) begin errors++; $display("FAIL mp_nt_redirect got %h want 0a", redirect_pc); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h05, 8'h06, 8'h40, 8'h05);
      tick();
      checks += 2;
      if (flush_out !== 1'b0) begin errors++; $display("FAIL b2b_flush step %0d got %0b want 0", k, flush_out); end
      if (branch_cnt !== 16'(k)) begin errors++; $display("FAIL b2b_bcnt got %0d want %0d", branch_cnt, k); end
    end
    // one not-taken step from strong-T must still predict taken
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h06, 8'h40, 8'h05);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05);
    #1;
    checks++;
    if (predict_taken !== 1'b1) begin errors++; $display("FAIL b2b_saturate_11 got %0b want 1", predict_taken); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03, 8'h04, 8'h90, 8'h03);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks += 3;
      if (branch_cnt !== 16'd0) begin errors++; $display("FAIL stall_bcnt cyc %0d got %0d want 0", k, branch_cnt); end
      if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL stall_mcnt cyc %0d got %0d want 0", k, mispredict_cnt); end
      if (flush_out !== 1'b0) begin errors++; $display("FAIL stall_flush cyc %0d got %0b want 0", k, flush_out); end
    end
    stall_mem = 1'b0;
    tick();
    checks += 3;
    if (branch_cnt !== 16'd1) begin errors++; $display("FAIL stall_release_bcnt got %0d want 1", branch_cnt); end
    if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL stall_release_mcnt got %0d want 1", mispredict_cnt); end
    if (flush_out !== 1'b1) begin errors++; $display("FAIL stall_release_flush got %0b want 1", flush_out); end
    branch_mem = 1'b0;
    tick();
    checks++;
    if (branch_cnt !== 16'd1) begin errors++; $display("FAIL stall_once got %0d want 1", branch_cnt); end
  endtask

  task automatic test_flush_shadow();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 8'h40, 8'h07);
    tick();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h07, 8'h08, 8'h80, 8'h07);
    tick();
    checks += 5;
    if (flush_out !== 1'b0) begin errors++; $display("FAIL shadow_flush got %0b want 0", flush_out); end
    if (mispredict_cnt !== 16'd1) begin errors++; $display("FAIL shadow_mcnt got %0d want 1", mispredict_cnt); end
    if (branch_cnt !== 16'd1) begin errors++; $display("FAIL shadow_bcnt got %0d want 1", branch_cnt); end
    if (redirect_pc !== 8'h40) begin errors++; $display("FAIL shadow_redirect got %h want 40", redirect_pc); end
    if (predict_taken !== 1'b0) begin errors++; $display("FAIL shadow_bht7 got %0b want 0", predict_taken); end
  endtask

  task automatic test_random();
    logic [7:0] pc;
    logic       p;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      pc = 8'($urandom_range(0, 255)) & 8'hF7;
      p  = ($urandom_range(0, 1) == 1) ? (m_bht[int'(pc) % 16] >= 2) : 1'($urandom_range(0, 1));
      drive(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), p,
            1'($urandom_range(0, 3) == 0), pc, pc + 8'd1, 8'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1) ? pc : 8'($urandom_range(0, 255)));
      #1;
      checks++;
      if (predict_taken !== (m_bht[int'(fetch_pc) % 16] >= 2))
        begin errors++; $display("FAIL rnd_predict n=%0d got %0b want %0b", n, predict_taken, m_bht[int'(fetch_pc) % 16] >= 2); end
      tick();
      checks += 4;
      if (flush_out !== 1'(m_flush)) begin errors++; $display("FAIL rnd_flush n=%0d got %0b want %0d", n, flush_out, m_flush); end
      if (redirect_pc !== 8'(m_redir)) begin errors++; $display("FAIL rnd_redirect n=%0d got %h want %h", n, redirect_pc, m_redir); end
      if (branch_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL rnd_bcnt n=%0d got %0d want %0d", n, branch_cnt, m_bcnt); end
      if (mispredict_cnt !== 16'(m_mcnt)) begin errors++; $display("FAIL rnd_mcnt n=%0d got %0d want %0d", n, mispredict_cnt, m_mcnt); end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'h02, 8'h03, 8'h20, 8'h00);
    for (int n = 0; n < 65536; n++) tick();
    checks += 2;
    if (branch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_bcnt got %h want ffff", branch_cnt); end
    if (branch_cnt !== 16'(m_bcnt)) begin errors++; $display("FAIL sat_bcnt_model got %h want %h", branch_cnt, m_bcnt); end
    tick();
    checks++;
    if (branch_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_bcnt_hold got %h want ffff", branch_cnt); end
    prediction_mem = 1'b0;
    tick();
    checks++;
    if (flush_out !== 1'b1) begin errors++; $display("FAIL sat_flush got %0b want 1", flush_out); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    checks += 2;
    if (flush_out !== 1'b0) begin errors++; $display("FAIL midflush_reset got %0b want 0", flush_out); end
    if (redirect_pc !== 8'h00) begin errors++; $display("FAIL midflush_redirect got %h want 00", redirect_pc); end
    // mispredict coincident with reset must not flush
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h05, 8'h06, 8'h40, 8'h05);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h05);
    checks += 3;
    if (flush_out !== 1'b0) begin errors++; $display("FAIL rst_prio_flush got %0b want 0", flush_out); end
    if (mispredict_cnt !== 16'd0) begin errors++; $display("FAIL rst_prio_mcnt got %0d want 0", mispredict_cnt); end
    if (predict_taken !== 1'b0) begin errors++; $display("FAIL rst_prio_bht got %0b want 0", predict_taken); end
    tick();
    checks++;
    if (flush_out !== 1'b0) begin errors++; $display("FAIL rst_prio_flush_late got %0b want 0", flush_out); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < 16; k++) m_bht[k] = 1;
    m_flush = 0; m_redir = 0; m_bcnt = 0; m_mcnt = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_mispredict();
    test_back_to_back();
    test_stall();
    test_flush_shadow();
    test_random();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
